// File: rtl/pontuacao_multi.sv
// pontuacao_multi: match scoreboard with rising-edge round detection, saturating per-player scores
// and thermometer LED bars. Define PONTUACAO_BLINK_EN to blink the champion's bar while in OVER.
module pontuacao_multi #(
    parameter int unsigned NPLAYERS   = 2,
    parameter int unsigned WIN_ROUNDS = 3,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NPLAYERS-1:0]   win_in,
    input  logic                  new_match,
    output logic [LED_W-1:0]      LED,
    output logic [4*NPLAYERS-1:0] score,
    output logic                  match_over,
    output logic [1:0]            champion,
    output logic                  round_ack,
    output logic                  conflict
);
    localparam int unsigned SliceW = LED_W / NPLAYERS;

    if (NPLAYERS < 2 || NPLAYERS > 4) begin : g_bad_nplayers
        $error("NPLAYERS must be in 2..4");
    end
    if (LED_W % NPLAYERS != 0) begin : g_bad_led_w
        $error("LED_W must be a multiple of NPLAYERS");
    end
    if (WIN_ROUNDS < 1 || WIN_ROUNDS > SliceW || WIN_ROUNDS > 15) begin : g_bad_win_rounds
        $error("WIN_ROUNDS must be in 1..LED_W/NPLAYERS and fit a 4-bit score");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("BLINK_DIV must be at least 2");
    end

    typedef enum logic [0:0] {StPlay, StOver} state_e;

    state_e                     state_q, state_d;
    logic [NPLAYERS-1:0]        win_q;
    logic [NPLAYERS-1:0][3:0]   scores_q, scores_d;
    logic [1:0]                 champion_q, champion_d;
    logic                       round_ack_q, round_ack_d;
    logic                       conflict_q, conflict_d;

    logic [NPLAYERS-1:0]        rise;
    logic                       rise_any, rise_single, rise_multi;
    logic [1:0]                 rise_idx;
    logic                       win_hit;
    logic                       blank;

    assign rise        = win_in & ~win_q;
    assign rise_any    = |rise;
    assign rise_single = rise_any && ((rise & (rise - NPLAYERS'(1))) == '0);
    assign rise_multi  = rise_any && !rise_single;

    // win_hit is only meaningful when exactly one rise bit is set.
    always_comb begin
        rise_idx = '0;
        win_hit  = 1'b0;
        for (int i = 0; i < NPLAYERS; i++) begin
            if (rise[i]) begin
                rise_idx = 2'(i);
                win_hit  = win_hit | (scores_q[i] == 4'(WIN_ROUNDS - 1));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StPlay;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPlay:  if (rise_single && win_hit) state_d = StOver;
            StOver:  if (new_match) state_d = StPlay;
            default: state_d = StPlay;
        endcase
    end

    always_comb begin
        scores_d    = scores_q;
        champion_d  = champion_q;
        round_ack_d = 1'b0;
        conflict_d  = 1'b0;
        unique case (state_q)
            StPlay: begin
                if (rise_single) begin
                    for (int i = 0; i < NPLAYERS; i++) begin
                        if (rise[i]) scores_d[i] = scores_q[i] + 4'd1;
                    end
                    round_ack_d = 1'b1;
                    if (win_hit) champion_d = rise_idx;
                end else if (rise_multi) begin
                    conflict_d = 1'b1;
                end
            end
            StOver: begin
                if (new_match) begin
                    scores_d   = '0;
                    champion_d = '0;
                end
            end
            default: ;
        endcase
    end

    // win_q loads all-ones on reset so a level held through reset is not a rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_q       <= '1;
            scores_q    <= '0;
            champion_q  <= '0;
            round_ack_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            win_q       <= win_in;
            scores_q    <= scores_d;
            champion_q  <= champion_d;
            round_ack_q <= round_ack_d;
            conflict_q  <= conflict_d;
        end
    end

`ifdef PONTUACAO_BLINK_EN
    localparam int unsigned     CntW   = $clog2(BLINK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_off_q, blink_off_d;

    // Held clear outside a steady OVER period so every match end starts lit.
    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == StOver && state_d == StOver) begin
            if (blink_cnt_q == CntMax) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CntW'(1);
                blink_off_d = blink_off_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blank = (state_q == StOver) && blink_off_q;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        match_over = (state_q == StOver);
        champion   = match_over ? champion_q : 2'd0;
        round_ack  = round_ack_q;
        conflict   = conflict_q;
        score      = scores_q;
    end

    always_comb begin
        LED = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            for (int j = 0; j < SliceW; j++) begin
                LED[i*SliceW + j] = (j < int'(scores_q[i])) && !(blank && (champion_q == 2'(i)));
            end
        end
    end

endmodule

// File: tb/tb_pontuacao_multi.sv
// Directed bench for pontuacao_multi (2 players, 3 rounds, 16 LEDs, BLINK_DIV=4).
module tb_pontuacao_multi;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  win_in;
    logic        new_match;
    logic [15:0] LED;
    logic [7:0]  score;
    logic        match_over;
    logic [1:0]  champion;
    logic        round_ack;
    logic        conflict;

    int n_checks = 0;
    int n_pass   = 0;

    pontuacao_multi #(
        .NPLAYERS   (2),
        .WIN_ROUNDS (3),
        .LED_W      (16),
        .BLINK_DIV  (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .win_in     (win_in),
        .new_match  (new_match),
        .LED        (LED),
        .score      (score),
        .match_over (match_over),
        .champion   (champion),
        .round_ack  (round_ack),
        .conflict   (conflict)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; win_in = 2'b01; new_match = 1'b0;
        tick(); tick();
        n_checks++;
        if (score !== 8'h00) $display("FAIL reset_score: got %h want %h", score, 8'h00);
        else n_pass++;
        n_checks++;
        if ({match_over, champion, round_ack, conflict} !== 5'b0)
            $display("FAIL reset_flags: got %b want %b",
                     {match_over, champion, round_ack, conflict}, 5'b0);
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({score, round_ack} !== 9'h000)
                $display("FAIL held_level_ignored: cycle %0d got score=%h ack=%b want 00/0",
                         k, score, round_ack);
            else n_pass++;
        end
        n_checks++;
        if (LED !== 16'h0000) $display("FAIL held_level_led: got %h want %h", LED, 16'h0000);
        else n_pass++;
    endtask

    task automatic test_score_p0();
        logic [7:0]  exp_score;
        logic [15:0] exp_led;
        win_in = 2'b00; tick();
        for (int k = 1; k <= 3; k++) begin
            exp_score = 8'(k);
            exp_led   = 16'((1 << k) - 1);
            win_in = 2'b01; tick();
            n_checks++;
            if ({score, LED, round_ack} !== {exp_score, exp_led, 1'b1})
                $display("FAIL p0_round%0d: got score=%h led=%h ack=%b want %h/%h/1",
                         k, score, LED, round_ack, exp_score, exp_led);
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if ({match_over, champion} !== 3'b100)
                    $display("FAIL p0_win: got over=%b champ=%0d want 1/0", match_over, champion);
                else n_pass++;
            end
            win_in = 2'b00; tick();
            n_checks++;
            if (round_ack !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", round_ack);
            else n_pass++;
            tick();
        end
        new_match = 1'b1; tick(); new_match = 1'b0;
        n_checks++;
        if ({match_over, score, LED} !== 25'h0)
            $display("FAIL p0_new_match: got over=%b score=%h led=%h want 0/00/0000",
                     match_over, score, LED);
        else n_pass++;
    endtask

    task automatic test_conflict();
        win_in = 2'b10; tick();
        n_checks++;
        if ({score, LED} !== {8'h10, 16'h0100})
            $display("FAIL p1_first: got score=%h led=%h want 10/0100", score, LED);
        else n_pass++;
        win_in = 2'b00; tick();
        win_in = 2'b11; tick();
        n_checks++;
        if ({conflict, round_ack, score} !== {1'b1, 1'b0, 8'h10})
            $display("FAIL conflict_pulse: got c=%b ack=%b score=%h want 1/0/10",
                     conflict, round_ack, score);
        else n_pass++;
        tick();
        n_checks++;
        if ({conflict, score} !== {1'b0, 8'h10})
            $display("FAIL conflict_one_cycle: got c=%b score=%h want 0/10", conflict, score);
        else n_pass++;
        win_in = 2'b00; tick();
    endtask

    task automatic test_over_ignore();
        for (int k = 0; k < 2; k++) begin
            win_in = 2'b10; tick();
            if (k == 0) begin
                win_in = 2'b00; tick();
            end
        end
        n_checks++;
        if ({score, LED, match_over, champion} !== {8'h30, 16'h0700, 1'b1, 2'd1})
            $display("FAIL p1_win: got score=%h led=%h over=%b champ=%0d want 30/0700/1/1",
                     score, LED, match_over, champion);
        else n_pass++;
        win_in = 2'b00; tick();
        win_in = 2'b10; tick();
        n_checks++;
        if ({score, round_ack} !== {8'h30, 1'b0})
            $display("FAIL over_rise_ignored: got score=%h ack=%b want 30/0", score, round_ack);
        else n_pass++;
        win_in = 2'b00; tick();
        win_in = 2'b11; tick();
        n_checks++;
        if ({conflict, round_ack} !== 2'b00)
            $display("FAIL over_conflict_ignored: got c=%b ack=%b want 0/0", conflict, round_ack);
        else n_pass++;
        win_in = 2'b00; tick();
        new_match = 1'b1; win_in = 2'b10; tick(); new_match = 1'b0;
        n_checks++;
        if ({score, LED, match_over, champion, round_ack} !== 28'h0)
            $display("FAIL new_match_clear: got score=%h led=%h over=%b champ=%0d ack=%b want 0s",
                     score, LED, match_over, champion, round_ack);
        else n_pass++;
        win_in = 2'b00; tick();
        win_in = 2'b10; tick();
        n_checks++;
        if ({score, round_ack} !== {8'h10, 1'b1})
            $display("FAIL after_new_match: got score=%h ack=%b want 10/1", score, round_ack);
        else n_pass++;
        win_in = 2'b00; tick();
        new_match = 1'b1; tick(); new_match = 1'b0;
        n_checks++;
        if ({score, match_over} !== {8'h10, 1'b0})
            $display("FAIL play_new_match_ignored: got score=%h over=%b want 10/0",
                     score, match_over);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        win_in = 2'b01; tick();
        win_in = 2'b00; tick();
        win_in = 2'b01; tick();
        n_checks++;
        if ({score, round_ack} !== {8'h12, 1'b1})
            $display("FAIL score_2_1: got score=%h ack=%b want 12/1", score, round_ack);
        else n_pass++;
        reset = 1'b1; win_in = 2'b00; tick(); reset = 1'b0;
        n_checks++;
        if ({score, LED, match_over, champion, round_ack, conflict} !== 29'h0)
            $display("FAIL mid_reset: got score=%h led=%h over=%b champ=%0d ack=%b c=%b want 0s",
                     score, LED, match_over, champion, round_ack, conflict);
        else n_pass++;
        tick();
        win_in = 2'b01; tick();
        n_checks++;
        if ({score, round_ack, match_over} !== {8'h01, 1'b1, 1'b0})
            $display("FAIL reset_to_play: got score=%h ack=%b over=%b want 01/1/0",
                     score, round_ack, match_over);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        // win_in[0] is still high from the previous task.
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({score, round_ack} !== {8'h01, 1'b0})
                $display("FAIL held_high_once: cycle %0d got score=%h ack=%b want 01/0",
                         k, score, round_ack);
            else n_pass++;
        end
        win_in = 2'b00; tick();
        win_in = 2'b01; tick();
        n_checks++;
        if ({score, round_ack} !== {8'h02, 1'b1})
            $display("FAIL rearmed: got score=%h ack=%b want 02/1", score, round_ack);
        else n_pass++;
        win_in = 2'b00; tick();
        win_in = 2'b01; tick();
        n_checks++;
        if ({score, match_over, champion} !== {8'h03, 1'b1, 2'd0})
            $display("FAIL b2b_win: got score=%h over=%b champ=%0d want 03/1/0",
                     score, match_over, champion);
        else n_pass++;
        win_in = 2'b00; tick();
    endtask

`ifdef PONTUACAO_BLINK_EN
    task automatic test_blink();
        logic [2:0] exp_slice;
        reset = 1'b1; tick(); reset = 1'b0;
        win_in = 2'b00; tick();
        win_in = 2'b01; tick();
        win_in = 2'b00; tick();
        for (int k = 0; k < 3; k++) begin
            win_in = 2'b10; tick();
            if (k < 2) begin
                win_in = 2'b00; tick();
            end
        end
        win_in = 2'b00;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            exp_slice = (((n / 4) % 2) == 0) ? 3'b111 : 3'b000;
            n_checks++;
            if ({LED[15:8], LED[7:0]} !== {5'b0, exp_slice, 8'h01})
                $display("FAIL blink_n%0d: got led=%h want %h", n, LED,
                         {5'b0, exp_slice, 8'h01});
            else n_pass++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; win_in = 2'b00; new_match = 1'b0;
        test_reset();
        test_score_p0();
        test_conflict();
        test_over_ignore();
        test_mid_reset();
        test_back_to_back();
`ifdef PONTUACAO_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pontuacao_multi.md
# pontuacao_multi

Parametrised match scoreboard for the Bulls and Cows board build, successor to the two-player `pontuacao` counter. It takes per-player round-win signals from the game core, detects rising edges, and keeps a saturating score per player. It declares a match winner at a configurable round count, then holds the result until an explicit new-match request. Scores drive the `LED` bank as per-player thermometer bars and are exported as binary for the display path.

## Interface

Parameters:
- `NPLAYERS`, 2: number of players; legal range 2..4.
- `WIN_ROUNDS`, 3: rounds needed to win the match; legal range 1..`LED_W/NPLAYERS`, otherwise elaboration error.
- `LED_W`, 16: width of `LED`; must be a multiple of `NPLAYERS`.
- `BLINK_DIV`, 25_000_000: half-period of the champion blink, in clock cycles; must be ≥ 2.

Ports:
- `clock`, input, 1: the single clock of the block.
- `reset`, input, 1: synchronous, active-high reset.
- `win_in`, input, `NPLAYERS`: round-win signal per player; pulse or level; only rising edges count.
- `new_match`, input, 1: request to clear scores and start a new match; honoured only in OVER.
- `LED`, output, `LED_W`: per-player thermometer bars.
- `score`, output, `4*NPLAYERS`: binary score; player i is in bits [4i+3:4i].
- `match_over`, output, 1: high while in OVER.
- `champion`, output, 2: index of the match winner; valid only while `match_over` is high, otherwise 0.
- `round_ack`, output, 1: one-cycle pulse on every accepted round win.
- `conflict`, output, 1: one-cycle pulse when two or more rising edges arrive in the same cycle.

Clock is `clock`. Reset `reset` is synchronous and active-high. There is one clock domain.

## Operation

- Edge detect: `win_q` registers `win_in` every cycle, in all states. `rise = win_in & ~win_q`.
- Reset loads `win_q` with all-ones. A level held high through reset is therefore not counted.
- States: PLAY and OVER. Reset enters PLAY.
- PLAY, exactly one bit of `rise` set (player p):
  - `score[p]` increments by 1.
  - `round_ack` pulses.
  - If the new score equals `WIN_ROUNDS`: `champion` is set to p and the FSM moves to OVER on the same edge.
- PLAY, two or more `rise` bits set: no score changes, `conflict` pulses, and the round is discarded.
- PLAY, `new_match` high: ignored.
- OVER:
  - All `rise` events are ignored; no `round_ack` and no `conflict`.
  - `new_match` high: all scores cleared, `champion` cleared, return to PLAY on the next edge.
  - A `rise` in the same cycle as `new_match` is discarded.
- Scores cannot exceed `WIN_ROUNDS`, because PLAY is left at that value.
- LED mapping: slice i is `LED[(i+1)*S-1 : i*S]` with S = `LED_W/NPLAYERS`. Bits [score-1:0] of the slice are lit, counting from the low end; the remaining bits are dark.
- Reset values:
  - scores 0
  - `LED` 0
  - `match_over` 0
  - `champion` 0
  - `round_ack` 0
  - `conflict` 0
  - blink counter 0

## Timing

- A rising edge sampled at clock edge k:
  - `score`, `LED`, `round_ack` or `conflict`, and `match_over` all update at edge k.
  - Latency is 1 cycle from the input being high at a sampling edge.
- `round_ack` and `conflict` are registered and high for exactly 1 cycle.
- Back-to-back: player p pulsing on consecutive cycles is one edge only. A new score needs `win_in[p]` low for at least one sampled cycle in between.
- `new_match` at edge k: `match_over` is low, and `score`/`LED` are 0, after edge k.
- `reset` asserted mid-match: all state returns to reset values at the next edge, regardless of FSM state.
- `LED` is decoded combinationally from registered state. It has no additional latency.

## Configuration

- `PONTUACAO_BLINK_EN` defined:
  - In OVER, the champion's slice toggles between its thermometer value and all-dark every `BLINK_DIV` cycles.
  - The blink counter clears on entry to OVER, so the slice starts lit.
  - Other slices stay steady.
- `PONTUACAO_BLINK_EN` undefined:
  - No blink counter is built.
  - The champion's slice stays steady.
  - All other behaviour is identical.

## Test plan

- Reset with `win_in`=2'b01 held, then release reset and hold 5 cycles -> no score, `round_ack` never pulses, `LED`=0.
- Defaults, player 0 with three 1-cycle pulses 3 cycles apart -> scores 1, 2, 3 one cycle after each pulse; `LED`=16'h0007; `match_over`=1 and `champion`=0 on the third edge.
- `win_in`=2'b11 rising in the same cycle -> `conflict` pulses for 1 cycle; scores unchanged; `round_ack`=0.
- In OVER, pulse player 1 and then assert `new_match` together with a player-1 rise -> the score is not incremented; after `new_match`, `score`=0, `LED`=0, `match_over`=0; the next clean player-1 rise gives score 1.
- Reset asserted with scores 2/1 in PLAY -> next cycle all outputs 0 and state PLAY.
- With `PONTUACAO_BLINK_EN`, `BLINK_DIV`=4, P1 champion at 3 -> `LED[10:8]` alternates 3'b111 / 3'b000 every 4 cycles, starting lit; `LED[7:0]` steady.
